// File: rtl/sipo_input_filter_pkg.sv
// Shared types and helpers for the SIPO input filter: control FSM states and a
// width helper for the debounce and timeout counters.
package sipo_input_filter_pkg;

    typedef enum logic {
        ST_UNPRIMED = 1'b0,
        ST_RUN      = 1'b1
    } state_e;

    // Bits needed to hold the value itself (never less than one).
    function automatic int get_width(input int value);
        return (value < 2) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/sipo_input_filter_if.sv
// Frame, filtered-state, edge-flag and interrupt signals between the
// deserializer/CPU side (master) and the input filter (slave).
interface sipo_input_filter_if #(parameter int WIDTH = 16);

    logic [WIDTH-1:0] raw;
    logic             raw_valid;
    logic [WIDTH-1:0] filt;
    logic             primed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr_rise;
    logic [WIDTH-1:0] clr_fall;
    logic [WIDTH-1:0] irq_mask;
    logic             irq;
    logic             stale;

    modport master (
        output raw, raw_valid, clr_rise, clr_fall, irq_mask,
        input  filt, primed, rise, fall, irq, stale
    );

    modport slave (
        input  raw, raw_valid, clr_rise, clr_fall, irq_mask,
        output filt, primed, rise, fall, irq, stale
    );

endinterface

// File: rtl/sipo_input_filter_bit.sv
// One debounced input bit: consecutive-difference counter, filtered state and
// the single-cycle edge strobes that feed the sticky flag registers.
module sipo_bit_filter
    import sipo_input_filter_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic aclr,
    input  logic sclr,
    input  logic ena,
    input  logic load,
    input  logic din,
    output logic q,
    output logic set_rise,
    output logic set_fall
);

    localparam int CNT_W = get_width(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;

    always_comb begin
        cnt_d    = cnt_q;
        q_d      = q_q;
        set_rise = 1'b0;
        set_fall = 1'b0;
        if (load) begin
            q_d = din;
        end else if (ena) begin
            if (din == q_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                q_d      = din;
                cnt_d    = '0;
                set_rise = din;
                set_fall = ~din;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else if (sclr) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sipo_input_filter.sv
// Debounces 74HC165 frames per bit, latches W1C edge flags with a maskable
// interrupt, and flags a stalled frame stream.
module sipo_input_filter
    import sipo_input_filter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 100000
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                sclr,
    sipo_input_filter_if.slave  bus
);

    localparam int TO_W = get_width(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic             ena, load;
    logic [WIDTH-1:0] filt, set_rise, set_fall;
    logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
    logic             irq_q, irq_d, stale_q, stale_d;
    logic [TO_W-1:0]  to_q, to_d;

    // The first frame only establishes the initial state; it is never an event.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ena     = 1'b0;
        case (state_q)
            ST_UNPRIMED: begin
                if (bus.raw_valid) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  ena = bus.raw_valid;
            default: state_d = ST_UNPRIMED;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sipo_bit_filter #(.FILTER_LEN(FILTER_LEN)) u_bit (
            .clk      (clk),
            .aclr     (aclr),
            .sclr     (sclr),
            .ena      (ena),
            .load     (load),
            .din      (bus.raw[i]),
            .q        (filt[i]),
            .set_rise (set_rise[i]),
            .set_fall (set_fall[i])
        );
    end

    always_comb begin
        rise_d  = (rise_q & ~bus.clr_rise) | set_rise;
        fall_d  = (fall_q & ~bus.clr_fall) | set_fall;
        irq_d   = (state_q == ST_RUN) && |((rise_q | fall_q) & bus.irq_mask);
        to_d    = bus.raw_valid ? '0 : ((to_q == TO_SAT) ? to_q : to_q + 1'b1);
        stale_d = !bus.raw_valid && ((to_q == TO_LAST) || stale_q);
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= ST_UNPRIMED;
            rise_q  <= '0;
            fall_q  <= '0;
            irq_q   <= 1'b0;
            stale_q <= 1'b0;
            to_q    <= '0;
        end else if (sclr) begin
            state_q <= ST_UNPRIMED;
            rise_q  <= '0;
            fall_q  <= '0;
            irq_q   <= 1'b0;
            stale_q <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
            stale_q <= stale_d;
            to_q    <= to_d;
        end
    end

    assign bus.filt   = filt;
    assign bus.primed = (state_q == ST_RUN);
    assign bus.rise   = rise_q;
    assign bus.fall   = fall_q;
    assign bus.irq    = irq_q;
    assign bus.stale  = stale_q;

endmodule

// File: tb/tb_sipo_input_filter.sv
// Randomized and directed bench for sipo_input_filter against a run-length
// reference model of the debounce, flag, interrupt and stale behaviour.
module tb_sipo_input_filter;

    localparam int W   = 16;
    localparam int FL  = 4;
    localparam int TO  = 10;

    logic clk = 1'b0;
    logic aclr;
    logic sclr;

    sipo_input_filter_if #(.WIDTH(W)) bus ();

    sipo_input_filter #(.WIDTH(W), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .aclr (aclr),
        .sclr (sclr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_filt, m_rise, m_fall;
    logic         m_primed, m_irq, m_stale;
    int           m_run [W];
    int           m_idle;

    function automatic void model_reset();
        m_filt = '0; m_rise = '0; m_fall = '0;
        m_primed = 1'b0; m_irq = 1'b0; m_stale = 1'b0;
        m_idle = 0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endfunction

    // Reference: a bit flips once FL consecutive frames disagree with it.
    function automatic void model_edge();
        logic [W-1:0] sr, sf;
        logic         irq_next;
        if (sclr) begin
            model_reset();
            return;
        end
        irq_next = m_primed && ((m_rise | m_fall) & bus.irq_mask) != 0;
        sr = '0; sf = '0;
        if (bus.raw_valid) begin
            if (!m_primed) begin
                m_filt   = bus.raw;
                m_primed = 1'b1;
            end else begin
                for (int i = 0; i < W; i++) begin
                    if (bus.raw[i] == m_filt[i]) begin
                        m_run[i] = 0;
                    end else begin
                        m_run[i]++;
                        if (m_run[i] == FL) begin
                            m_filt[i] = bus.raw[i];
                            m_run[i]  = 0;
                            if (bus.raw[i]) sr[i] = 1'b1; else sf[i] = 1'b1;
                        end
                    end
                end
            end
        end
        m_rise = (m_rise & ~bus.clr_rise) | sr;
        m_fall = (m_fall & ~bus.clr_fall) | sf;
        m_irq  = irq_next;
        if (bus.raw_valid) m_idle = 0;
        else if (m_idle < TO) m_idle++;
        m_stale = (m_idle >= TO);
    endfunction

    task automatic step(input logic [W-1:0] r, input logic v,
                        input logic [W-1:0] cr, input logic [W-1:0] cf,
                        input logic sc);
        bus.raw       = r;
        bus.raw_valid = v;
        bus.clr_rise  = cr;
        bus.clr_fall  = cf;
        sclr          = sc;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic frames(input logic [W-1:0] r, input int n);
        for (int k = 0; k < n; k++) step(r, 1'b1, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.filt, bus.rise, bus.fall, bus.primed, bus.irq, bus.stale} !== '0) begin
            errors++;
            $display("FAIL reset_outputs actual filt=%h rise=%h fall=%h primed=%b irq=%b stale=%b required all 0",
                     bus.filt, bus.rise, bus.fall, bus.primed, bus.irq, bus.stale);
        end
    endtask

    task automatic test_first_frame();
        step(16'hA5A5, 1'b1, '0, '0, 1'b0);
        checks++;
        if (bus.filt !== 16'hA5A5 || bus.primed !== 1'b1) begin
            errors++;
            $display("FAIL first_frame actual filt=%h primed=%b required filt=a5a5 primed=1", bus.filt, bus.primed);
        end
        checks++;
        if (bus.rise !== '0 || bus.fall !== '0 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL first_frame_no_event actual rise=%h fall=%h irq=%b required 0", bus.rise, bus.fall, bus.irq);
        end
    endtask

    task automatic test_glitch_filter();
        bus.irq_mask = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            step(16'hA5A4, 1'b1, '0, '0, 1'b0);
            step(16'hA5A4, 1'b0, '0, '0, 1'b0);
        end
        checks++;
        if (bus.filt[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_three_frames actual filt0=%b required 1", bus.filt[0]);
        end
        frames(16'hA5A5, 1);
        frames(16'hA5A4, 3);
        checks++;
        if (bus.filt[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_after_reset_run actual filt0=%b required 1", bus.filt[0]);
        end
        frames(16'hA5A4, 1);
        checks++;
        if (bus.filt !== 16'hA5A4 || bus.fall[0] !== 1'b1 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL fall_accept actual filt=%h fall0=%b irq=%b required filt=a5a4 fall0=1 irq=0",
                     bus.filt, bus.fall[0], bus.irq);
        end
        step(16'hA5A4, 1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.irq !== 1'b1) begin
            errors++;
            $display("FAIL fall_irq actual irq=%b required 1", bus.irq);
        end
    endtask

    task automatic test_w1c_collision();
        bus.irq_mask = 16'h0008;
        step(16'hA5A4, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        frames(16'hA5AC, 4);
        frames(16'hA5A4, 4);
        step(16'hA5A4, 1'b0, '0, 16'h0008, 1'b0);
        checks++;
        if (bus.rise[3] !== 1'b1 || bus.fall[3] !== 1'b0) begin
            errors++;
            $display("FAIL w1c_setup actual rise3=%b fall3=%b required rise3=1 fall3=0", bus.rise[3], bus.fall[3]);
        end
        frames(16'hA5AC, 3);
        step(16'hA5AC, 1'b1, 16'h0008, '0, 1'b0);
        checks++;
        if (bus.rise[3] !== 1'b1) begin
            errors++;
            $display("FAIL w1c_set_wins actual rise3=%b required 1", bus.rise[3]);
        end
        step(16'hA5AC, 1'b0, 16'h0008, '0, 1'b0);
        checks++;
        if (bus.rise[3] !== 1'b0 || bus.irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_clear actual rise3=%b irq=%b required rise3=0 irq=1", bus.rise[3], bus.irq);
        end
        step(16'hA5AC, 1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_irq_drop actual irq=%b required 0", bus.irq);
        end
    endtask

    task automatic test_irq_mask();
        bus.irq_mask = 16'h0000;
        frames(16'hA58C, 4);
        step(16'hA58C, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        frames(16'hA5AC, 4);
        step(16'hA5AC, 1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.rise !== 16'h0020 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_off actual rise=%h irq=%b required rise=0020 irq=0", bus.rise, bus.irq);
        end
        bus.irq_mask = 16'h0020;
        step(16'hA5AC, 1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.irq !== 1'b1) begin
            errors++;
            $display("FAIL mask_on actual irq=%b required 1", bus.irq);
        end
    endtask

    task automatic test_stale();
        frames(16'hA5AC, 1);
        for (int k = 1; k <= TO; k++) begin
            step(16'hA5AC, 1'b0, '0, '0, 1'b0);
            if (k >= TO - 1) begin
                checks++;
                if (bus.stale !== (k == TO)) begin
                    errors++;
                    $display("FAIL stale_timing idle=%0d actual stale=%b required %b", k, bus.stale, k == TO);
                end
            end
        end
        frames(16'hA5AC, 1);
        checks++;
        if (bus.stale !== 1'b0 || bus.filt !== 16'hA5AC) begin
            errors++;
            $display("FAIL stale_clear actual stale=%b filt=%h required stale=0 filt=a5ac", bus.stale, bus.filt);
        end
    endtask

    task automatic test_sclr_mid_debounce();
        frames(16'hA5AD, 2);
        step(16'hA5AD, 1'b1, '0, '0, 1'b1);
        checks++;
        if ({bus.filt, bus.rise, bus.fall, bus.primed, bus.irq, bus.stale} !== '0) begin
            errors++;
            $display("FAIL sclr_clear actual filt=%h rise=%h fall=%h primed=%b irq=%b stale=%b required all 0",
                     bus.filt, bus.rise, bus.fall, bus.primed, bus.irq, bus.stale);
        end
        frames(16'h1234, 1);
        checks++;
        if (bus.filt !== 16'h1234 || bus.primed !== 1'b1 || bus.rise !== '0 || bus.fall !== '0) begin
            errors++;
            $display("FAIL sclr_reload actual filt=%h primed=%b rise=%h fall=%h required filt=1234 primed=1 no flags",
                     bus.filt, bus.primed, bus.rise, bus.fall);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] base;
        logic [W-1:0] noise;
        logic [W-1:0] cr, cf;
        logic         v, sc;
        int           quiet;
        base  = W'($urandom);
        quiet = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) base[$urandom_range(0, W - 1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) bus.irq_mask = W'($urandom);
            if (quiet == 0 && $urandom_range(0, 60) == 0) quiet = $urandom_range(8, 14);
            noise = W'($urandom & $urandom & $urandom);
            v     = (quiet > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (quiet > 0) quiet--;
            cr    = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            cf    = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            sc    = ($urandom_range(0, 249) == 0);
            step(base ^ noise, v, cr, cf, sc);
            checks++;
            if ({bus.filt, bus.rise, bus.fall, bus.primed, bus.irq, bus.stale} !==
                {m_filt, m_rise, m_fall, m_primed, m_irq, m_stale}) begin
                errors++;
                $display("FAIL random_cycle%0d actual filt=%h rise=%h fall=%h p=%b irq=%b stale=%b required filt=%h rise=%h fall=%h p=%b irq=%b stale=%b",
                         n, bus.filt, bus.rise, bus.fall, bus.primed, bus.irq, bus.stale,
                         m_filt, m_rise, m_fall, m_primed, m_irq, m_stale);
            end
        end
    endtask

    initial begin
        aclr          = 1'b1;
        sclr          = 1'b0;
        bus.raw       = '0;
        bus.raw_valid = 1'b0;
        bus.clr_rise  = '0;
        bus.clr_fall  = '0;
        bus.irq_mask  = '0;
        model_reset();
        #23;
        aclr = 1'b0;
        #1;
        test_reset();
        test_first_frame();
        test_glitch_filter();
        test_w1c_collision();
        test_irq_mask();
        test_stale();
        test_sclr_mid_debounce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
